// File: rtl/burst_strobe_gen_pkg.sv
// Shared state encoding, default limits and width helper for the burst strobe generator
// and the capture controller that reuses the same timing states.
package burst_strobe_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam int PERIOD_MAX_DEF = 65535;
   localparam int BURST_MAX_DEF  = 255;

   // Bits needed to hold v (65535 -> 16, 255 -> 8); never less than one.
   function automatic int func_log2(input int v);
      int bits;
      bits = 1;
      for (int i = 1; i < 32; i++) begin
         if ((v >> i) != 0) begin
            bits = i + 1;
         end else begin
            bits = bits;
         end
      end
      return bits;
   endfunction

endpackage

// File: rtl/burst_strobe_gen_phase_divider.sv
// Phase divider: counts 1..period and flags the cycle whose registered strobe is due.
// o_tick is combinational so the caller can register the strobe on the same edge.
module phase_divider #(
   parameter int PW = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_load,
   input  logic          i_ena,
   input  logic [PW-1:0] i_period,
   output logic          o_tick
);

   localparam logic [PW-1:0] ONE = PW'(1);

   logic [PW-1:0] r_phase;
   logic [PW-1:0] r_period;
   logic [PW-1:0] w_next;
   logic [PW-1:0] w_per;

   // Next phase value; loading starts at phase 1 so period=1 strobes on the very next cycle.
   always_comb begin
      w_per  = r_period;
      w_next = r_phase;
      if (i_load) begin
         w_per  = i_period;
         w_next = ONE;
      end else if (i_ena) begin
         w_per = r_period;
         if (r_phase == r_period) begin
            w_next = ONE;
         end else begin
            w_next = r_phase + ONE;
         end
      end else begin
         w_per  = r_period;
         w_next = r_phase;
      end
      o_tick = (i_load | i_ena) & (w_next == w_per);
   end

   // Phase and latched period registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase  <= {PW{1'b0}};
         r_period <= {PW{1'b0}};
      end else if (i_load) begin
         r_phase  <= w_next;
         r_period <= i_period;
      end else if (i_ena) begin
         r_phase <= w_next;
      end else begin
         r_phase <= r_phase;
      end
   end

endmodule

// File: rtl/burst_strobe_gen.sv
// Programmable strobe generator: one-cycle enables every period clocks, for a finite
// burst or continuously, with start/stop control and busy/done/cfg_err status.
module burst_strobe_gen
   import burst_strobe_gen_pkg::*;
#(
   parameter int PERIOD_MAX = PERIOD_MAX_DEF,
   parameter int BURST_MAX  = BURST_MAX_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           stop,
   input  logic [func_log2(PERIOD_MAX)-1:0] period,
   input  logic [func_log2(BURST_MAX)-1:0]  burst_len,
   output logic                           strobe,
   output logic [func_log2(BURST_MAX)-1:0]  strobe_idx,
   output logic                           busy,
   output logic                           done,
   output logic                           cfg_err
);

   localparam int PW = func_log2(PERIOD_MAX);
   localparam int BW = func_log2(BURST_MAX);

   state_t        r_state;
   logic          r_strobe;
   logic [BW-1:0] r_idx;
   logic          r_busy;
   logic          r_done;
   logic          r_cfg_err;
   logic          r_last;
   logic [BW-1:0] r_cnt;
   logic [BW-1:0] r_blen;

   logic          w_accept;
   logic          w_run_ena;
   logic          w_tick;
   logic          w_final;
   logic [BW-1:0] w_cnt_base;
   logic [BW-1:0] w_blen;

   phase_divider #(.PW(PW)) u_phase_divider (
      .i_clk    (clk),
      .i_rst_n  (rst),
      .i_load   (w_accept),
      .i_ena    (w_run_ena),
      .i_period (period),
      .o_tick   (w_tick)
   );

   // On an accepted start the counters restart from the freshly presented burst length.
   always_comb begin
      w_accept  = (r_state == ST_IDLE) && start && !stop && (period != {PW{1'b0}});
      w_run_ena = (r_state == ST_RUN) && !stop && !r_last;
      if (w_accept) begin
         w_cnt_base = {BW{1'b0}};
         w_blen     = burst_len;
      end else begin
         w_cnt_base = r_cnt;
         w_blen     = r_blen;
      end
      w_final = w_tick && (w_blen != {BW{1'b0}}) && (w_cnt_base == (w_blen - BW'(1)));
   end

   // Control FSM, strobe counter and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_strobe  <= 1'b0;
         r_idx     <= {BW{1'b0}};
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         r_last    <= 1'b0;
         r_cnt     <= {BW{1'b0}};
         r_blen    <= {BW{1'b0}};
      end else begin
         r_strobe  <= w_tick;
         r_idx     <= w_tick ? w_cnt_base : {BW{1'b0}};
         r_cnt     <= w_cnt_base + BW'(w_tick);
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_last <= w_final;
               if (w_accept) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
                  r_blen  <= burst_len;
               end else if (start && !stop) begin
                  r_busy    <= 1'b0;
                  r_cfg_err <= 1'b1;
               end else begin
                  r_busy <= 1'b0;
               end
            end
            ST_RUN: begin
               // Stop beats the pending FINISH, so a stop on the final strobe suppresses done.
               if (stop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_last  <= 1'b0;
               end else if (r_last) begin
                  r_state <= ST_FINISH;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_last  <= 1'b0;
               end else begin
                  r_busy <= 1'b1;
                  r_last <= w_final;
               end
            end
            ST_FINISH: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_last  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_last  <= 1'b0;
            end
         endcase
      end
   end

   assign strobe     = r_strobe;
   assign strobe_idx = r_idx;
   assign busy       = r_busy;
   assign done       = r_done;
   assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_burst_strobe_gen.sv
// Scoreboard bench for burst_strobe_gen: a timing model predicts strobe/done/cfg_err
// events and the busy window; a monitor compares them against the DUT every cycle.
`timescale 1ns/1ps
module tb_burst_strobe_gen;

   localparam int PW = 16;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          stop;
   logic [PW-1:0] period;
   logic [BW-1:0] burst_len;
   logic          strobe;
   logic [BW-1:0] strobe_idx;
   logic          busy;
   logic          done;
   logic          cfg_err;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   int exp_lo = 1;
   int exp_hi = 0;

   typedef struct {
      int         cyc;
      logic [2:0] kind;
      int         idx;
   } ev_t;

   ev_t q[$];

   burst_strobe_gen dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .period     (period),
      .burst_len  (burst_len),
      .strobe     (strobe),
      .strobe_idx (strobe_idx),
      .busy       (busy),
      .done       (done),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int t, input logic [2:0] k, input int idx);
      ev_t e;
      e.cyc  = t;
      e.kind = k;
      e.idx  = idx;
      q.push_back(e);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_strobe"}, int'(strobe), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_cfg_err"}, int'(cfg_err), 0);
      chk({tag, "_idx"}, int'(strobe_idx), 0);
   endtask

   // Reference timing: start driven in cycle c; strobe n at c+(n+1)*p; stop driven in
   // cycle s removes every strobe after s; done one cycle after the last strobe.
   task automatic model_txn(input int c, input int p, input int l, input int stop_k,
                            output int end_c);
      int  n;
      int  t;
      int  tl;
      bit  has_stop;
      has_stop = (stop_k >= 0);
      if (p == 0) begin
         push(c + 1, 3'b100, 0);
         exp_lo = 1;
         exp_hi = 0;
         end_c  = c + 2;
         return;
      end
      tl = (l != 0) ? c + l * p : -1;
      n  = 0;
      while (n < 4000) begin
         t = c + (n + 1) * p;
         if (l != 0 && n >= l) break;
         if (has_stop && t > stop_k) break;
         push(t, 3'b001, n % 256);
         n++;
      end
      exp_lo = c + 1;
      if (l != 0 && !(has_stop && stop_k <= tl)) begin
         push(tl + 1, 3'b010, 0);
         exp_hi = tl;
         end_c  = tl + 2;
      end else begin
         exp_hi = stop_k;
         end_c  = stop_k + 1;
      end
   endtask

   // One transaction: start, optional stop/async reset, optional disturbance while running.
   task automatic run_txn(input int p, input int l, input int stop_rel, input int rst_rel,
                          input bit noise);
      int c;
      int end_c;
      int stop_k;
      c      = cyc;
      stop_k = (stop_rel >= 0) ? c + stop_rel : -1;
      period    = PW'(p);
      burst_len = BW'(l);
      start     = 1'b1;
      stop      = 1'b0;
      model_txn(c, p, l, stop_k, end_c);
      forever begin
         @(negedge clk);
         start = 1'b0;
         stop  = 1'b0;
         if (rst_rel >= 0 && cyc == c + rst_rel) begin
            rst = 1'b0;
            #1;
            check_idle_outputs("async_reset");
            q.delete();
            exp_lo = 1;
            exp_hi = 0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            break;
         end
         if (rst_rel < 0 && cyc >= end_c) break;
         if (cyc == stop_k) stop = 1'b1;
         if (noise && cyc <= exp_hi) begin
            period    = PW'($urandom_range(0, 3));
            burst_len = BW'($urandom_range(0, 3));
            start     = ($urandom_range(0, 2) == 0);
         end
      end
   endtask

   // Monitor: busy every cycle, and each strobe/done/cfg_err pulse against the queue head.
   initial begin
      ev_t e;
      forever begin
         @(posedge clk);
         #1;
         chk("busy", int'(busy), int'(cyc >= exp_lo && cyc <= exp_hi));
         while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_event cyc=%0d got none expected kind=%b at cyc %0d",
                     cyc, q[0].kind, q[0].cyc);
            void'(q.pop_front());
         end
         if (strobe || done || cfg_err) begin
            if (q.size() == 0 || q[0].cyc != cyc) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event cyc=%0d got kind=%b expected none",
                        cyc, {cfg_err, done, strobe});
            end else begin
               e = q.pop_front();
               chk("event_kind", int'({cfg_err, done, strobe}), int'(e.kind));
               if (e.kind == 3'b001) chk("strobe_idx", int'(strobe_idx), e.idx);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d got no finish expected finish", cyc);
      $fatal(1);
   end

   initial begin
      int p;
      int l;
      int sr;
      bit nz;
      rst       = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      period    = '0;
      burst_len = '0;
      @(negedge clk);
      check_idle_outputs("reset");
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      run_txn(4, 3, -1, -1, 1'b0);
      run_txn(1, 0, 6, -1, 1'b0);
      run_txn(0, 0, -1, -1, 1'b0);
      run_txn(2, 1, -1, -1, 1'b0);
      run_txn(5, 4, -1, -1, 1'b1);
      run_txn(3, 10, -1, 7, 1'b0);
      repeat (8) @(negedge clk);
      run_txn(3, 10, -1, 6, 1'b0);
      repeat (4) @(negedge clk);
      run_txn(2, 2, 4, -1, 1'b0);

      // start and stop together in IDLE: ignored, even with period 0
      period = 16'd3; burst_len = 8'd1; start = 1'b1; stop = 1'b1;
      @(negedge clk);
      period = 16'd0; start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      repeat (6) @(negedge clk);

      run_txn(1, 0, 300, -1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         p = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
         l = int'($urandom_range(0, 5));
         if (l == 0) sr = int'($urandom_range(1, 25));
         else if ($urandom_range(0, 1) == 1) sr = int'($urandom_range(1, l * (p + 1) + 2));
         else sr = -1;
         nz = 1'($urandom_range(0, 1));
         run_txn(p, l, sr, -1, nz);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
